conv_transposed_1d_stream: RTL and testbench
============================================

CONV_TRANSPOSED_1D_STREAM -- requirements
Module: conv_transposed_1d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed input sample and weight width.
REQ-002 SHALL have parameter ACC_W, default 40, meaning signed accumulator and output width; ACC_W >= 2*DATA_W + clog2(KERNEL_SIZE).
REQ-003 SHALL have parameter KERNEL_SIZE, default 3, meaning tap count K, 1..16.
REQ-004 SHALL have parameter STRIDE, default 2, meaning upsampling stride S, 1..K.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_W, signed sample) and in_last (input, 1, final sample of frame).
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, ACC_W, signed) and out_last (output, 1).
REQ-009 SHALL have ports w_wr_en (input, 1), w_wr_addr (input, clog2(K)), w_wr_data (input, DATA_W) and bias (input, ACC_W, quasi-static).
REQ-010 SHALL have port busy (output, 1), high while a frame is in progress.

Function
REQ-011 SHALL compute y[n] = bias + sum of x[i]*w[k] over all i*S + k = n, with no padding, for n = 0..(L-1)*S+K-1, where L is the frame length.
REQ-012 SHALL hold accumulator window acc[0..K-1], all zero between frames.
REQ-013 SHALL use FSM states ACCEPT, EMIT and FLUSH; reset state is ACCEPT.
REQ-014 ACCEPT: in_ready=1, out_valid=0; on in_valid, acc[k] += in_data*w[k] for all k in that cycle, set busy, go to EMIT.
REQ-015 EMIT: out_valid=1 and out_data=acc[0]+bias; on out_ready, shift acc down one place with zero fill into acc[K-1]; after S handshakes go to ACCEPT, or to FLUSH if the captured in_last was 1 and K>S.
REQ-016 FLUSH: emit as in EMIT for K-S handshakes, then go to ACCEPT and clear busy.
REQ-017 out_last SHALL be 1 on the final output of a frame: the last FLUSH output, or the S-th EMIT output when K==S.
REQ-018 Latency: the first output of a sample SHALL be valid the cycle after input acceptance.
REQ-019 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Arithmetic SHALL be signed two's complement, with products sign-extended to ACC_W and wrap-around on overflow (no saturation).
REQ-021 A weight write SHALL take effect the next cycle when busy=0; it SHALL be ignored when busy=1.
REQ-022 If in_valid and w_wr_en are both asserted in ACCEPT with busy=0, the sample SHALL use the old weights.
REQ-023 An in_last=1 sample SHALL end the frame; the next accepted sample starts a new frame with acc all zero.

Reset
REQ-024 rst_n low SHALL asynchronously force state ACCEPT, acc to zero, weights to zero, busy=0, out_valid=0, out_last=0, out_data=0 and in_ready=0 while rst_n is low.
REQ-025 Reset mid-frame SHALL discard the frame; no output of it SHALL appear after release.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the default DATA_W, ACC_W, KERNEL_SIZE and STRIDE constants.
REQ-027 The K-way multiply-add SHALL be one sub-module, conv_t1d_mac_array (inputs: sample, weight vector, acc vector; output: updated acc vector; combinational).
REQ-028 Illegal parameters (S>K, or K outside 1..16) SHALL fail at elaboration.

Verification
REQ-029 K=3, S=2, w=[1,2,3], bias=0, input [1,1] with in_last on the second sample -> outputs [1,2,4,2,3], out_last on the 5th.
REQ-030 Same weights, single sample -2 with in_last -> outputs [-6+... ] not applicable; required outputs are [-2,-4,-6], with out_last on -6.
REQ-031 bias=5, w=[1,2,3], input [1,1] with in_last; out_ready toggled 1,0,0,1 repeatedly -> [6,7,9,7,8] with no loss or duplication and data held while stalled.
REQ-032 w_wr_en to address 0 with data 9 while busy=1 -> write ignored; the following frame still uses w[0]=1.
REQ-033 rst_n asserted after the 2nd output of a frame -> all outputs 0 immediately; after release, a new frame [1] produces [1,2,3].
REQ-034 K=S=2, w=[1,1], input [3,4] with in_last -> outputs [3,3,4,4], out_last on the 4th, FLUSH never entered.

Source files
------------

// File: rtl/conv_transposed_1d_stream_pkg.sv
// Shared constants and FSM state type for the streaming 1-D transposed convolution.
package conv_transposed_1d_stream_pkg;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_ACC_W       = 40;
    localparam int unsigned DEF_KERNEL_SIZE = 3;
    localparam int unsigned DEF_STRIDE      = 2;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        EMIT   = 2'd1,
        FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/conv_transposed_1d_stream_mac.sv
// Combinational K-way multiply-add: acc_o[k] = acc_i[k] + sample * w[k].
module conv_t1d_mac_array #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned KERNEL_SIZE = 3
) (
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [DATA_W-1:0] w_i   [KERNEL_SIZE],
    input  logic signed [ACC_W-1:0]  acc_i [KERNEL_SIZE],
    output logic signed [ACC_W-1:0]  acc_o [KERNEL_SIZE]
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod [KERNEL_SIZE];

    // Full-precision product per tap, sign-extended into the wrapping accumulator.
    always_comb begin
        for (int k = 0; k < int'(KERNEL_SIZE); k++) begin
            prod[k]  = sample_i * w_i[k];
            acc_o[k] = acc_i[k] + ACC_W'(prod[k]);
        end
    end

endmodule

// File: rtl/conv_transposed_1d_stream.sv
// Streaming 1-D transposed convolution: each accepted sample is scattered into a
// K-deep accumulator window, then STRIDE outputs are shifted out; the window
// tail is flushed after the last sample of a frame.
module conv_transposed_1d_stream
    import conv_transposed_1d_stream_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int unsigned STRIDE      = DEF_STRIDE,
    localparam int unsigned AW         = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last,
    input  logic                     w_wr_en,
    input  logic [AW-1:0]            w_wr_addr,
    input  logic signed [DATA_W-1:0] w_wr_data,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     busy
);

    localparam int unsigned CW = $clog2(KERNEL_SIZE + 1);

    // Reject illegal geometries at elaboration.
    if (KERNEL_SIZE < 1 || KERNEL_SIZE > 16) begin : g_bad_k
        $error("KERNEL_SIZE must be in 1..16");
    end
    if (STRIDE < 1 || STRIDE > KERNEL_SIZE) begin : g_bad_s
        $error("STRIDE must be in 1..KERNEL_SIZE");
    end
    if (ACC_W < 2 * DATA_W + $clog2(KERNEL_SIZE)) begin : g_bad_acc
        $error("ACC_W too narrow for DATA_W and KERNEL_SIZE");
    end

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     last_q, last_d;
    logic                     busy_q, busy_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;
    logic signed [DATA_W-1:0] w_q   [KERNEL_SIZE];
    logic signed [DATA_W-1:0] w_d   [KERNEL_SIZE];
    logic signed [ACC_W-1:0]  acc_q [KERNEL_SIZE];
    logic signed [ACC_W-1:0]  acc_d [KERNEL_SIZE];
    logic signed [ACC_W-1:0]  acc_mac [KERNEL_SIZE];
    logic                     out_hs;

    conv_t1d_mac_array #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_mac (
        .sample_i (in_data),
        .w_i      (w_q),
        .acc_i    (acc_q),
        .acc_o    (acc_mac)
    );

    assign out_hs = out_valid_q && out_ready;

    // Next-state, window update and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        busy_d  = busy_q;
        w_d     = w_q;
        acc_d   = acc_q;

        if (w_wr_en && !busy_q && (32'(w_wr_addr) < KERNEL_SIZE)) begin
            w_d[w_wr_addr] = w_wr_data;
        end

        case (state_q)
            ACCEPT: begin
                if (in_valid && in_ready_q) begin
                    acc_d   = acc_mac;
                    last_d  = in_last;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_hs) begin
                    for (int k = 0; k < int'(KERNEL_SIZE) - 1; k++) begin
                        acc_d[k] = acc_q[k+1];
                    end
                    acc_d[KERNEL_SIZE-1] = '0;
                    if (32'(cnt_q) + 32'd1 == STRIDE) begin
                        cnt_d = '0;
                        if (last_q && (KERNEL_SIZE > STRIDE)) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = ACCEPT;
                            if (last_q) begin
                                busy_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                if (out_hs) begin
                    for (int k = 0; k < int'(KERNEL_SIZE) - 1; k++) begin
                        acc_d[k] = acc_q[k+1];
                    end
                    acc_d[KERNEL_SIZE-1] = '0;
                    if (32'(cnt_q) + 32'd1 == KERNEL_SIZE - STRIDE) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ACCEPT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase

        in_ready_d  = (state_d == ACCEPT);
        out_valid_d = (state_d != ACCEPT);
        out_data_d  = out_valid_d ? (acc_d[0] + bias) : '0;
        out_last_d  = ((state_d == EMIT) && (KERNEL_SIZE == STRIDE) && last_d
                       && (32'(cnt_d) + 32'd1 == STRIDE))
                   || ((state_d == FLUSH) && (32'(cnt_d) + 32'd1 == KERNEL_SIZE - STRIDE));
    end

    // State, window, weights and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCEPT;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < int'(KERNEL_SIZE); k++) begin
                w_q[k]   <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            for (int k = 0; k < int'(KERNEL_SIZE); k++) begin
                w_q[k]   <= w_d[k];
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_transposed_1d_stream.sv
// Directed bench: K=3/S=2 instance for most scenarios, K=S=2 instance for the no-flush case.
module tb_conv_transposed_1d_stream;

    logic               clk;
    logic               rst_n;
    logic               sel;
    logic               in_valid, in_last, out_ready, w_wr_en;
    logic signed [15:0] in_data, w_wr_data;
    logic [1:0]         w_wr_addr;
    logic signed [39:0] bias;

    logic               in_ready1, out_valid1, out_last1, busy1;
    logic signed [39:0] out_data1;
    logic               in_ready2, out_valid2, out_last2, busy2;
    logic signed [39:0] out_data2;

    logic               o_in_ready, o_valid, o_last, o_busy;
    logic signed [39:0] o_data;

    int                 n_checks = 0;
    int                 n_fail   = 0;

    int                 in_vec   [8];
    bit                 last_vec [8];
    logic signed [39:0] got_data [16];
    logic               got_last [16];
    int                 got_n;
    int                 stall_viol;
    bit                 timed_out;

    conv_transposed_1d_stream #(
        .DATA_W(16), .ACC_W(40), .KERNEL_SIZE(3), .STRIDE(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && !sel), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
        .w_wr_en(w_wr_en && !sel), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .bias(bias), .busy(busy1)
    );

    conv_transposed_1d_stream #(
        .DATA_W(16), .ACC_W(40), .KERNEL_SIZE(2), .STRIDE(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2),
        .w_wr_en(w_wr_en && sel), .w_wr_addr(w_wr_addr[0]), .w_wr_data(w_wr_data),
        .bias(bias), .busy(busy2)
    );

    assign o_in_ready = sel ? in_ready2  : in_ready1;
    assign o_valid    = sel ? out_valid2 : out_valid1;
    assign o_data     = sel ? out_data2  : out_data1;
    assign o_last     = sel ? out_last2  : out_last1;
    assign o_busy     = sel ? busy2      : busy1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_weight(input logic [1:0] a, input int d);
        @(negedge clk);
        w_wr_en   = 1'b1;
        w_wr_addr = a;
        w_wr_data = 16'(d);
        @(negedge clk);
        w_wr_en   = 1'b0;
    endtask

    // Drives in_vec[0..n_in-1] and records output handshakes until exp_n are seen or the budget expires.
    task automatic run_frame(input int n_in, input int exp_n, input int pat,
                             input int wr_at, input logic [1:0] wa, input int wd);
        int                 idx;
        int                 cyc;
        bit                 took;
        bit                 have_stall;
        logic signed [39:0] sd;
        logic               sl;
        idx = 0; cyc = 0; got_n = 0; stall_viol = 0; have_stall = 1'b0;
        sd = '0; sl = 1'b0;
        while (got_n < exp_n && cyc < 300) begin
            @(negedge clk);
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_valid  = (idx < n_in);
            in_data   = (idx < n_in) ? 16'(in_vec[idx]) : 16'sd0;
            in_last   = (idx < n_in) ? last_vec[idx] : 1'b0;
            w_wr_en   = (idx == wr_at);
            w_wr_addr = wa;
            w_wr_data = 16'(wd);
            #1;
            if (have_stall && (o_valid !== 1'b1 || o_data !== sd || o_last !== sl)) stall_viol++;
            have_stall = o_valid && !out_ready;
            sd = o_data;
            sl = o_last;
            if (o_valid && out_ready) begin
                got_data[got_n] = o_data;
                got_last[got_n] = o_last;
                got_n++;
            end
            took = in_valid && o_in_ready;
            @(posedge clk);
            if (took) idx++;
            cyc++;
        end
        #1;
        in_valid = 1'b0; in_last = 1'b0; w_wr_en = 1'b0; out_ready = 1'b1;
        timed_out = (got_n < exp_n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL reset out_valid: got %b want 0", o_valid); end
        n_checks++; if (o_data !== 40'sd0)   begin n_fail++; $display("FAIL reset out_data: got %0d want 0", o_data); end
        n_checks++; if (o_last !== 1'b0)     begin n_fail++; $display("FAIL reset out_last: got %b want 0", o_last); end
        n_checks++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", o_in_ready); end
        n_checks++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset busy: got %b want 0", o_busy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset in_ready: got %b want 1", o_in_ready); end
    endtask

    task automatic test_basic();
        longint exp_d [5] = '{1, 2, 4, 2, 3};
        int extra;
        write_weight(2'd0, 1); write_weight(2'd1, 2); write_weight(2'd2, 3);
        in_vec[0] = 1; last_vec[0] = 1'b0;
        in_vec[1] = 1; last_vec[1] = 1'b1;
        run_frame(2, 5, 0, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic count: got %0d want 5", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_d[i]) || got_last[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL basic out[%0d]: got %0d last %b want %0d last %b", i, got_data[i], got_last[i], exp_d[i], (i == 4));
            end
        end
        extra = 0;
        repeat (4) begin @(negedge clk); if (o_valid) extra++; end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL basic extra outputs: got %0d want 0", extra); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic busy after frame: got %b want 0", o_busy); end
    endtask

    task automatic test_single_negative();
        longint exp_d [3] = '{-2, -4, -6};
        in_vec[0] = -2; last_vec[0] = 1'b1;
        run_frame(1, 3, 0, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL neg count: got %0d want 3", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_d[i]) || got_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL neg out[%0d]: got %0d last %b want %0d last %b", i, got_data[i], got_last[i], exp_d[i], (i == 2));
            end
        end
    endtask

    task automatic test_backpressure();
        longint exp_d [5] = '{6, 7, 9, 7, 8};
        bias = 40'sd5;
        in_vec[0] = 1; last_vec[0] = 1'b0;
        in_vec[1] = 1; last_vec[1] = 1'b1;
        run_frame(2, 5, 1, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall count: got %0d want 5", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_d[i]) || got_last[i] !== (i == 4)) begin
                n_fail++;
                $display("FAIL stall out[%0d]: got %0d last %b want %0d last %b", i, got_data[i], got_last[i], exp_d[i], (i == 4));
            end
        end
        n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall hold: got %0d changes want 0", stall_viol); end
        bias = 40'sd0;
    endtask

    task automatic test_weight_write_busy();
        longint exp_a [5] = '{1, 2, 4, 2, 3};
        longint exp_b [3] = '{1, 2, 3};
        in_vec[0] = 1; last_vec[0] = 1'b0;
        in_vec[1] = 1; last_vec[1] = 1'b1;
        run_frame(2, 5, 0, 1, 2'd0, 9);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL busywr count: got %0d want 5", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_a[i])) begin
                n_fail++; $display("FAIL busywr frame out[%0d]: got %0d want %0d", i, got_data[i], exp_a[i]);
            end
        end
        in_vec[0] = 1; last_vec[0] = 1'b1;
        run_frame(1, 3, 0, -1, 2'd0, 0);
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_b[i])) begin
                n_fail++; $display("FAIL busywr next out[%0d]: got %0d want %0d", i, got_data[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_same_cycle_write();
        longint exp_a [3] = '{1, 2, 3};
        longint exp_b [3] = '{7, 2, 3};
        in_vec[0] = 1; last_vec[0] = 1'b1;
        run_frame(1, 3, 0, 0, 2'd0, 7);
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_a[i])) begin
                n_fail++; $display("FAIL samecyc old out[%0d]: got %0d want %0d", i, got_data[i], exp_a[i]);
            end
        end
        run_frame(1, 3, 0, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL samecyc count: got %0d want 3", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_b[i])) begin
                n_fail++; $display("FAIL samecyc new out[%0d]: got %0d want %0d", i, got_data[i], exp_b[i]);
            end
        end
        write_weight(2'd0, 1);
    endtask

    task automatic test_reset_mid_frame();
        longint exp_d [3] = '{1, 2, 3};
        int extra;
        in_vec[0] = 1; last_vec[0] = 1'b0;
        in_vec[1] = 1; last_vec[1] = 1'b1;
        run_frame(2, 2, 0, -1, 2'd0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", o_valid); end
        n_checks++; if (o_data !== 40'sd0) begin n_fail++; $display("FAIL midrst out_data: got %0d want 0", o_data); end
        n_checks++; if (o_busy !== 1'b0)   begin n_fail++; $display("FAIL midrst busy: got %b want 0", o_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (5) begin @(negedge clk); if (o_valid) extra++; end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL midrst stale outputs: got %0d want 0", extra); end
        write_weight(2'd0, 1); write_weight(2'd1, 2); write_weight(2'd2, 3);
        in_vec[0] = 1; last_vec[0] = 1'b1;
        run_frame(1, 3, 0, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL midrst count: got %0d want 3", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_d[i]) || got_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL midrst out[%0d]: got %0d last %b want %0d last %b", i, got_data[i], got_last[i], exp_d[i], (i == 2));
            end
        end
    endtask

    task automatic test_k_eq_s();
        longint exp_d [4] = '{3, 3, 4, 4};
        sel = 1'b1;
        write_weight(2'd0, 1); write_weight(2'd1, 1);
        in_vec[0] = 3; last_vec[0] = 1'b0;
        in_vec[1] = 4; last_vec[1] = 1'b1;
        run_frame(2, 4, 0, -1, 2'd0, 0);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL keqs count: got %0d want 4", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_checks++;
            if (got_data[i] !== 40'(exp_d[i]) || got_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL keqs out[%0d]: got %0d last %b want %0d last %b", i, got_data[i], got_last[i], exp_d[i], (i == 3));
            end
        end
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL keqs idle after frame: valid %b busy %b want 0 0", o_valid, o_busy);
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; bias = '0;
        test_reset();
        test_basic();
        test_single_negative();
        test_backpressure();
        test_weight_write_busy();
        test_same_cycle_write();
        test_reset_mid_frame();
        test_k_eq_s();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
